count_wrap_monitor: RTL and testbench



---
 rtl/count_wrap_monitor.sv | 117 +++++++++++
 tb/tb_count_wrap_monitor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/count_wrap_monitor.sv
// Monitors a free-running WIDTH-bit counter: legal moves are hold, +1, or MAX->0 wrap; counts wraps, flags stalls and illegal jumps.
// All outputs registered, 1-clock latency. Optional macro CNT_DOWN_EN adds a `dir` input allowing down-counting sequences.
module count_wrap_monitor #(
    parameter int WIDTH       = 4,
    parameter int WRAP_W      = 8,
    parameter int STALL_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  cnt,
    input  logic              enable,
    input  logic              clear_fault,
`ifdef CNT_DOWN_EN
    input  logic              dir,
`endif
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              stall,
    output logic              fault,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        FAULT = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] MAX   = '1;
    localparam logic [7:0]       LIMIT = 8'(STALL_LIMIT);

    state_t            st;
    logic [WIDTH-1:0]  prev;
    logic [7:0]        stall_run;

    logic              is_hold;
    logic              is_step;
    logic              is_wrap;
    logic [7:0]        run_inc;
    logic [WIDTH-1:0]  up_nxt;

    assign state   = st;
    assign up_nxt  = prev + WIDTH'(1);
    assign is_hold = (cnt == prev);
    assign run_inc = (stall_run == LIMIT) ? stall_run : stall_run + 8'd1;

    // Wrap is decoded from the explicit endpoints, never from adder overflow.
`ifdef CNT_DOWN_EN
    logic [WIDTH-1:0] dn_nxt;
    assign dn_nxt  = prev - WIDTH'(1);
    assign is_step = dir ? ((prev != '0) && (cnt == dn_nxt))
                         : ((prev != MAX) && (cnt == up_nxt));
    assign is_wrap = dir ? ((prev == '0) && (cnt == MAX))
                         : ((prev == MAX) && (cnt == '0));
`else
    assign is_step = (prev != MAX) && (cnt == up_nxt);
    assign is_wrap = (prev == MAX) && (cnt == '0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            st         <= IDLE;
            prev       <= '0;
            stall_run  <= '0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
            stall      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            case (st)
                IDLE: begin
                    stall_run <= '0;
                    stall     <= 1'b0;
                    if (enable) begin
                        prev <= cnt;
                        st   <= TRACK;
                    end
                end
                TRACK: begin
                    prev <= cnt;
                    if (!enable) begin
                        // Disarm wins over any check of this sample.
                        st        <= IDLE;
                        stall_run <= '0;
                        stall     <= 1'b0;
                    end else if (is_hold) begin
                        stall_run <= run_inc;
                        stall     <= (run_inc == LIMIT);
                    end else if (is_wrap) begin
                        wrap_pulse <= 1'b1;
                        if (wrap_count != '1)
                            wrap_count <= wrap_count + WRAP_W'(1);
                        stall_run <= '0;
                        stall     <= 1'b0;
                    end else if (is_step) begin
                        stall_run <= '0;
                        stall     <= 1'b0;
                    end else begin
                        st        <= FAULT;
                        fault     <= 1'b1;
                        stall_run <= '0;
                        stall     <= 1'b0;
                    end
                end
                FAULT: begin
                    if (clear_fault) begin
                        st    <= IDLE;
                        fault <= 1'b0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Randomized and directed bench for count_wrap_monitor against an arithmetic reference model; also runs a WRAP_W=2 instance on the same stimulus.
module tb_count_wrap_monitor;

    localparam int LIMIT = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cnt = '0;
    logic       enable = 1'b0;
    logic       clear_fault = 1'b0;
    logic       dir = 1'b0;

    logic       wrap_pulse, stall, fault;
    logic [7:0] wrap_count;
    logic [1:0] state;
    logic       wrap_pulse2, stall2, fault2;
    logic [1:0] wrap_count2;
    logic [1:0] state2;

    int total = 0;
    int bad   = 0;

    // reference model: mode 0 idle, 1 track, 2 fault
    int m_mode, m_prev, m_run, m_wraps, m_pulse, m_stall, m_fault;
    int pulses_seen;

    always #5 clock = ~clock;

    count_wrap_monitor #(.WIDTH(4), .WRAP_W(8), .STALL_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset), .cnt(cnt), .enable(enable),
        .clear_fault(clear_fault),
`ifdef CNT_DOWN_EN
        .dir(dir),
`endif
        .wrap_pulse(wrap_pulse), .wrap_count(wrap_count), .stall(stall),
        .fault(fault), .state(state)
    );

    count_wrap_monitor #(.WIDTH(4), .WRAP_W(2), .STALL_LIMIT(LIMIT)) dut2 (
        .clock(clock), .reset(reset), .cnt(cnt), .enable(enable),
        .clear_fault(clear_fault),
`ifdef CNT_DOWN_EN
        .dir(dir),
`endif
        .wrap_pulse(wrap_pulse2), .wrap_count(wrap_count2), .stall(stall2),
        .fault(fault2), .state(state2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_edge(int c, int en, int clr, int rst, int d);
        int up_ok, wrap_ok;
        if (d != 0) begin
            up_ok   = (m_prev != 0) && (c == m_prev - 1);
            wrap_ok = (m_prev == 0) && (c == 15);
        end else begin
            up_ok   = (m_prev != 15) && (c == m_prev + 1);
            wrap_ok = (m_prev == 15) && (c == 0);
        end
        m_pulse = 0;
        if (rst != 0) begin
            m_mode = 0; m_prev = 0; m_run = 0; m_wraps = 0; m_stall = 0; m_fault = 0;
        end else if (m_mode == 0) begin
            m_run = 0; m_stall = 0;
            if (en != 0) begin m_prev = c; m_mode = 1; end
        end else if (m_mode == 1) begin
            if (en == 0) begin
                m_mode = 0; m_run = 0; m_stall = 0;
            end else if (c == m_prev) begin
                m_run   = (m_run + 1 > LIMIT) ? LIMIT : m_run + 1;
                m_stall = (m_run >= LIMIT) ? 1 : 0;
            end else if (wrap_ok != 0) begin
                m_wraps++; m_pulse = 1; m_run = 0; m_stall = 0;
            end else if (up_ok != 0) begin
                m_run = 0; m_stall = 0;
            end else begin
                m_mode = 2; m_fault = 1; m_run = 0; m_stall = 0;
            end
            m_prev = c;
        end else if (clr != 0) begin
            m_mode = 0; m_fault = 0;
        end
    endfunction

    task automatic step(input int c, input int en, input int clr, input int rst);
        cnt = 4'(c); enable = en[0]; clear_fault = clr[0]; reset = rst[0];
        @(posedge clock);
        model_edge(c, en, clr, rst, int'(dir));
        #1;
        if (wrap_pulse === 1'b1) pulses_seen++;
        chk("state",       32'(state),       32'(m_mode));
        chk("wrap_pulse",  32'(wrap_pulse),  32'(m_pulse));
        chk("wrap_count",  32'(wrap_count),  32'((m_wraps > 255) ? 255 : m_wraps));
        chk("stall",       32'(stall),       32'(m_stall));
        chk("fault",       32'(fault),       32'(m_fault));
        chk("wrap_count2", 32'(wrap_count2), 32'((m_wraps > 3) ? 3 : m_wraps));
        chk("state2",      32'(state2),      32'(m_mode));
    endtask

    initial begin
        int r, c, en, clr, rst;
        m_mode = 0; m_prev = 0; m_run = 0; m_wraps = 0; m_pulse = 0; m_stall = 0; m_fault = 0;
        pulses_seen = 0;

        // 1: reset with enable high and cnt=9, then arm
        step(9, 1, 0, 1);
        step(9, 1, 0, 1);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_count", 32'(wrap_count), 32'd0);
        step(0, 1, 0, 0);
        chk("arm_state", 32'(state), 32'd1);

        // 2: 40-sample legal sequence with two wraps
        pulses_seen = 0;
        for (int i = 1; i < 40; i++) step(i % 16, 1, 0, 0);
        chk("seq_pulses", 32'(pulses_seen), 32'd2);
        chk("seq_wraps", 32'(wrap_count), 32'd2);
        chk("seq_fault", 32'(fault), 32'd0);

        // 3: stall after 8 equal comparisons, clears on the step
        step(0, 1, 0, 1);
        step(4, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(5, 1, 0, 0);
        chk("stall_hi", 32'(stall), 32'd1);
        step(6, 1, 0, 0);
        chk("stall_lo", 32'(stall), 32'd0);

        // 4: jump, ignored samples, clear, re-arm
        step(0, 1, 0, 1);
        step(2, 1, 0, 0);
        step(3, 1, 0, 0);
        step(7, 1, 0, 0);
        chk("jump_state", 32'(state), 32'd2);
        step(8, 1, 0, 0);
        step(9, 1, 0, 0);
        chk("fault_frozen_wc", 32'(wrap_count), 32'd0);
        step(9, 1, 1, 0);
        chk("clear_state", 32'(state), 32'd0);
        chk("clear_fault", 32'(fault), 32'd0);
        step(9, 1, 0, 0);
        chk("rearm_state", 32'(state), 32'd1);

        // 5: five wraps saturate the 2-bit counter at 3
        step(0, 1, 0, 1);
        pulses_seen = 0;
        for (int i = 0; i < 81; i++) step(i % 16, 1, 0, 0);
        chk("sat_pulses", 32'(pulses_seen), 32'd5);
        chk("sat_wc2", 32'(wrap_count2), 32'd3);
        chk("sat_wc", 32'(wrap_count), 32'd5);

        // 6: disarm at 15, re-arm at 2, no wrap/fault
        step(0, 1, 0, 1);
        step(14, 1, 0, 0);
        step(15, 0, 0, 0);
        step(2, 1, 0, 0);
        step(3, 1, 0, 0);
        chk("disarm_fault", 32'(fault), 32'd0);
        chk("disarm_wc", 32'(wrap_count), 32'd0);
`ifdef CNT_DOWN_EN
        dir = 1'b1;
        step(2, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(15, 1, 0, 0);
        chk("down_wc", 32'(wrap_count), 32'd1);
        chk("down_fault", 32'(fault), 32'd0);
        dir = 1'b0;
        step(0, 1, 0, 1);
        step(5, 1, 0, 0);
`endif
        step(4, 1, 0, 0);
        step(3, 1, 0, 0);
        chk("down_jump_fault", 32'(fault), 32'd1);

        // random phase: mostly legal moves with occasional jumps, disarms, clears and resets
        step(0, 1, 0, 1);
        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 99));
`ifdef CNT_DOWN_EN
            if ($urandom_range(0, 9) == 0) dir = ~dir;
`endif
            if (r < 55)      c = (dir == 1'b1) ? (m_prev + 15) % 16 : (m_prev + 1) % 16;
            else if (r < 80) c = m_prev;
            else             c = int'($urandom_range(0, 15));
            en  = ($urandom_range(0, 19) == 0) ? 0 : 1;
            clr = ($urandom_range(0, 4) == 0) ? 1 : 0;
            rst = ($urandom_range(0, 99) == 0) ? 1 : 0;
            step(c, en, clr, rst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
